alu2_sequencer: RTL and testbench
=================================

// Module: alu2_sequencer
// PURPOSE
//  Command-side initiator for the 8-bit ripple-carry alu2 ALU; drives its enable/write/strobe protocol.
//  Accepts one command per valid/ready handshake and loads the operands into the ALU.
//  Strobes the ALU, waits for ready to fall then rise, and returns result, flags and carry on a valid/ready response port.
//  Keeps a chained carry register so multi-byte ADC/SUB sequences run with no software carry handling.
// PARAMETERS
//  LOAD_CYCLES   2   cycles tx_alu_write is held high in LOAD (>=2, covers ALU write sync)
//  SETTLE_CYCLES 2   cycles with write low before strobe (>=2, lets ALU write register clear)
//  TIMEOUT       31  max BUSY cycles before abort; counter width $clog2(TIMEOUT+1)
// PORTS
//  aclk             in   1  clock, all logic on rising edge
//  aresetn          in   1  asynchronous active-low reset
//  rx_cmd_valid     in   1  command valid
//  tx_cmd_ready     out  1  high only in IDLE
//  rx_cmd_opcode    in   3  ALU opcode: 0 NOP,1 ADC,2 SUB,3 ROL,4 ROR,5 AND,6 ORR,7 EOR
//  rx_cmd_operand0  in   8  operand 0
//  rx_cmd_operand1  in   8  operand 1
//  rx_cmd_usecarry  in   1  1: feed chained carry register into the ALU; 0: feed 0
//  rx_carry_clear   in   1  synchronous clear of the chained carry register
//  tx_alu_enable    out  1  ALU enable
//  tx_alu_write     out  1  ALU register-write request
//  tx_alu_strobe    out  1  ALU start strobe
//  tx_alu_opcode    out  3  latched opcode
//  tx_alu_operand0  out  8  latched operand 0
//  tx_alu_operand1  out  8  latched operand 1
//  tx_alu_carryflag out  1  carry into ALU
//  rx_alu_result    in   8  ALU result
//  rx_alu_carryflag in   1  ALU carry out
//  rx_alu_zeroflag  in   1  ALU zero flag
//  rx_alu_signflag  in   1  ALU sign flag
//  rx_alu_ready     in   1  ALU idle
//  tx_rsp_valid     out  1  response valid
//  rx_rsp_ready     in   1  response accepted
//  tx_rsp_result    out  8  captured result
//  tx_rsp_flags     out  3  {carry,zero,sign} captured
//  tx_rsp_timeout   out  1  1 = command aborted by timeout; result/flags are 0
// BEHAVIOUR
//  Reset: state IDLE; carry register 0. Every output is 0 except tx_cmd_ready=1.
//  tx_alu_enable is 1 in every state except IDLE and RESP.
//  IDLE: on rx_cmd_valid, latch the command and go to LOAD.
//   The carry register is sampled into tx_alu_carryflag at accept; it stays stable until the next accept.
//  LOAD: tx_alu_write=1 for LOAD_CYCLES cycles, then go to SETTLE.
//  SETTLE: write=0, strobe=0 for SETTLE_CYCLES cycles, then go to STROBE.
//  STROBE: tx_alu_strobe=1 for exactly 1 cycle, then go to BUSY; clear seen_low and the timeout counter.
//  BUSY: rx_alu_ready=0 sets seen_low.
//   First cycle with seen_low=1 and rx_alu_ready=1: capture rx_alu_* into tx_rsp_*, timeout=0, go to RESP.
//   Counter reaches TIMEOUT before that: tx_rsp_* = 0, timeout=1, go to RESP.
//  RESP: tx_rsp_valid=1; result, flags and timeout are held stable until rx_rsp_ready=1, then go to IDLE.
//  Carry register: loaded with the captured carry on a successful BUSY->RESP transition; not touched on timeout.
//   rx_carry_clear clears it in any state and wins over a same-cycle capture.
//  Throughput: one command per LOAD_CYCLES+SETTLE_CYCLES+1+busy+1+rsp cycles.
//   Min latency from accept to tx_rsp_valid = LOAD_CYCLES+SETTLE_CYCLES+1+(ALU busy)+1.
//  rx_cmd_* are ignored outside IDLE; no queueing.
//  rx_rsp_ready with tx_rsp_valid=0 has no effect.
//  Reset asserted mid-operation: all outputs return to reset values at once; the ALU is re-synced by its own reset.
//  The counter saturates and never wraps.
// TESTING
//  ADC 0x7F+0x01, usecarry=0 -> result 0x80, flags {0,0,1}, timeout=0, carry reg 0.
//  ADC 0xFF+0x01, then ADC 0x00+0x00 with usecarry=1 -> results 0x00 {1,1,0} then 0x01, carry reg 0.
//  Same carry chain with rx_carry_clear between the two commands -> second result 0x00, zero=1.
//  Model ALU that never drops ready -> tx_rsp_timeout=1 after TIMEOUT BUSY cycles, result 0x00, carry reg unchanged.
//  Hold rx_rsp_ready=0 for 10 cycles -> tx_rsp_* stable, tx_cmd_ready=0 throughout; new cmd accepted 1 cycle after release.
//  aresetn pulsed low during BUSY -> all outputs 0, tx_cmd_ready=1, next EOR 0xF0^0xFF -> 0x0F.

Source files
------------

// File: rtl/alu2_sequencer.sv
// Command-side sequencer for the 8-bit alu2 ALU: accepts a command, walks the ALU's
// write/settle/strobe/busy protocol and returns result, flags and carry on a response port.
module alu2_sequencer #(
    parameter int LOAD_CYCLES   = 2,
    parameter int SETTLE_CYCLES = 2,
    parameter int TIMEOUT       = 31
) (
    input  logic       aclk,
    input  logic       aresetn,
    input  logic       rx_cmd_valid,
    output logic       tx_cmd_ready,
    input  logic [2:0] rx_cmd_opcode,
    input  logic [7:0] rx_cmd_operand0,
    input  logic [7:0] rx_cmd_operand1,
    input  logic       rx_cmd_usecarry,
    input  logic       rx_carry_clear,
    output logic       tx_alu_enable,
    output logic       tx_alu_write,
    output logic       tx_alu_strobe,
    output logic [2:0] tx_alu_opcode,
    output logic [7:0] tx_alu_operand0,
    output logic [7:0] tx_alu_operand1,
    output logic       tx_alu_carryflag,
    input  logic [7:0] rx_alu_result,
    input  logic       rx_alu_carryflag,
    input  logic       rx_alu_zeroflag,
    input  logic       rx_alu_signflag,
    input  logic       rx_alu_ready,
    output logic       tx_rsp_valid,
    input  logic       rx_rsp_ready,
    output logic [7:0] tx_rsp_result,
    output logic [2:0] tx_rsp_flags,
    output logic       tx_rsp_timeout
);

    localparam int PH_MAX = (LOAD_CYCLES > SETTLE_CYCLES) ? LOAD_CYCLES : SETTLE_CYCLES;
    localparam int PH_W   = $clog2(PH_MAX + 1);
    localparam int TO_W   = $clog2(TIMEOUT + 1);

    localparam logic [PH_W-1:0] LOAD_LAST   = PH_W'(LOAD_CYCLES - 1);
    localparam logic [PH_W-1:0] SETTLE_LAST = PH_W'(SETTLE_CYCLES - 1);
    localparam logic [TO_W-1:0] TO_LAST     = TO_W'(TIMEOUT - 1);
    localparam logic [TO_W-1:0] TO_MAX      = TO_W'(TIMEOUT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SETTLE,
        S_STROBE,
        S_BUSY,
        S_RESP
    } state_t;

    state_t          state;
    logic [PH_W-1:0] phase_cnt;
    logic [TO_W-1:0] tmo_cnt;
    logic            seen_low;
    logic            carry_q;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state            <= S_IDLE;
            phase_cnt        <= '0;
            tmo_cnt          <= '0;
            seen_low         <= 1'b0;
            carry_q          <= 1'b0;
            tx_cmd_ready     <= 1'b1;
            tx_alu_enable    <= 1'b0;
            tx_alu_write     <= 1'b0;
            tx_alu_strobe    <= 1'b0;
            tx_alu_opcode    <= '0;
            tx_alu_operand0  <= '0;
            tx_alu_operand1  <= '0;
            tx_alu_carryflag <= 1'b0;
            tx_rsp_valid     <= 1'b0;
            tx_rsp_result    <= '0;
            tx_rsp_flags     <= '0;
            tx_rsp_timeout   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (rx_cmd_valid) begin
                        tx_alu_opcode    <= rx_cmd_opcode;
                        tx_alu_operand0  <= rx_cmd_operand0;
                        tx_alu_operand1  <= rx_cmd_operand1;
                        tx_alu_carryflag <= rx_cmd_usecarry & carry_q;
                        tx_cmd_ready     <= 1'b0;
                        tx_alu_enable    <= 1'b1;
                        tx_alu_write     <= 1'b1;
                        phase_cnt        <= '0;
                        state            <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (phase_cnt == LOAD_LAST) begin
                        tx_alu_write <= 1'b0;
                        phase_cnt    <= '0;
                        state        <= S_SETTLE;
                    end else begin
                        phase_cnt <= phase_cnt + PH_W'(1);
                    end
                end
                S_SETTLE: begin
                    if (phase_cnt == SETTLE_LAST) begin
                        tx_alu_strobe <= 1'b1;
                        state         <= S_STROBE;
                    end else begin
                        phase_cnt <= phase_cnt + PH_W'(1);
                    end
                end
                S_STROBE: begin
                    tx_alu_strobe <= 1'b0;
                    seen_low      <= 1'b0;
                    tmo_cnt       <= '0;
                    state         <= S_BUSY;
                end
                S_BUSY: begin
                    // Completion needs a full low-then-high cycle of ALU ready, not a stale high.
                    if (!rx_alu_ready) seen_low <= 1'b1;
                    if (tmo_cnt != TO_MAX) tmo_cnt <= tmo_cnt + TO_W'(1);
                    if (seen_low && rx_alu_ready) begin
                        tx_rsp_result  <= rx_alu_result;
                        tx_rsp_flags   <= {rx_alu_carryflag, rx_alu_zeroflag, rx_alu_signflag};
                        tx_rsp_timeout <= 1'b0;
                        carry_q        <= rx_alu_carryflag;
                        tx_rsp_valid   <= 1'b1;
                        tx_alu_enable  <= 1'b0;
                        state          <= S_RESP;
                    end else if (tmo_cnt == TO_LAST) begin
                        tx_rsp_result  <= '0;
                        tx_rsp_flags   <= '0;
                        tx_rsp_timeout <= 1'b1;
                        tx_rsp_valid   <= 1'b1;
                        tx_alu_enable  <= 1'b0;
                        state          <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (rx_rsp_ready) begin
                        tx_rsp_valid <= 1'b0;
                        tx_cmd_ready <= 1'b1;
                        state        <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
            // Placed last so an explicit clear overrides a same-cycle carry capture.
            if (rx_carry_clear) carry_q <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu2_sequencer.sv
// Randomized bench for alu2_sequencer with a behavioural ALU stub and a transaction-level
// scoreboard that tracks the chained carry and expected response latency.
module tb_alu2_sequencer;

    localparam int LC = 2;
    localparam int SC = 2;
    localparam int TO = 31;

    logic       aclk = 1'b0;
    logic       aresetn = 1'b0;
    logic       rx_cmd_valid = 1'b0;
    logic       tx_cmd_ready;
    logic [2:0] rx_cmd_opcode = '0;
    logic [7:0] rx_cmd_operand0 = '0;
    logic [7:0] rx_cmd_operand1 = '0;
    logic       rx_cmd_usecarry = 1'b0;
    logic       rx_carry_clear = 1'b0;
    logic       tx_alu_enable;
    logic       tx_alu_write;
    logic       tx_alu_strobe;
    logic [2:0] tx_alu_opcode;
    logic [7:0] tx_alu_operand0;
    logic [7:0] tx_alu_operand1;
    logic       tx_alu_carryflag;
    logic [7:0] rx_alu_result;
    logic       rx_alu_carryflag;
    logic       rx_alu_zeroflag;
    logic       rx_alu_signflag;
    logic       rx_alu_ready;
    logic       tx_rsp_valid;
    logic       rx_rsp_ready = 1'b0;
    logic [7:0] tx_rsp_result;
    logic [2:0] tx_rsp_flags;
    logic       tx_rsp_timeout;

    int n_cmp = 0;
    int n_err = 0;
    int alu_delay = 2;
    logic alu_hang = 1'b0;
    logic model_carry = 1'b0;

    alu2_sequencer #(.LOAD_CYCLES(LC), .SETTLE_CYCLES(SC), .TIMEOUT(TO)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .rx_cmd_valid(rx_cmd_valid), .tx_cmd_ready(tx_cmd_ready),
        .rx_cmd_opcode(rx_cmd_opcode), .rx_cmd_operand0(rx_cmd_operand0),
        .rx_cmd_operand1(rx_cmd_operand1), .rx_cmd_usecarry(rx_cmd_usecarry),
        .rx_carry_clear(rx_carry_clear),
        .tx_alu_enable(tx_alu_enable), .tx_alu_write(tx_alu_write), .tx_alu_strobe(tx_alu_strobe),
        .tx_alu_opcode(tx_alu_opcode), .tx_alu_operand0(tx_alu_operand0),
        .tx_alu_operand1(tx_alu_operand1), .tx_alu_carryflag(tx_alu_carryflag),
        .rx_alu_result(rx_alu_result), .rx_alu_carryflag(rx_alu_carryflag),
        .rx_alu_zeroflag(rx_alu_zeroflag), .rx_alu_signflag(rx_alu_signflag),
        .rx_alu_ready(rx_alu_ready),
        .tx_rsp_valid(tx_rsp_valid), .rx_rsp_ready(rx_rsp_ready),
        .tx_rsp_result(tx_rsp_result), .tx_rsp_flags(tx_rsp_flags), .tx_rsp_timeout(tx_rsp_timeout)
    );

    always #5 aclk = ~aclk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // {carry_out, result} of the 8-bit ALU
    function automatic logic [8:0] alu_ref(input logic [2:0] op, input logic [7:0] a,
                                           input logic [7:0] b, input logic c);
        case (op)
            3'd1:    return {1'b0, a} + {1'b0, b} + {8'd0, c};
            3'd2:    return {1'b0, a} + {1'b0, ~b} + {8'd0, c};
            3'd3:    return {a[7], a[6:0], c};
            3'd4:    return {a[0], c, a[7:1]};
            3'd5:    return {1'b0, a & b};
            3'd6:    return {1'b0, a | b};
            3'd7:    return {1'b0, a ^ b};
            default: return 9'd0;
        endcase
    endfunction

    // ALU stub: on strobe drops ready for alu_delay cycles then presents the result
    initial begin
        logic [8:0] cr;
        rx_alu_ready = 1'b1;
        rx_alu_result = 8'h5A;
        rx_alu_carryflag = 1'b1;
        rx_alu_zeroflag = 1'b0;
        rx_alu_signflag = 1'b0;
        forever begin
            @(negedge aclk);
            if (tx_alu_strobe && alu_hang) begin
                rx_alu_result = 8'hA5;
                rx_alu_carryflag = 1'b1;
                rx_alu_zeroflag = 1'b0;
                rx_alu_signflag = 1'b1;
            end else if (tx_alu_strobe) begin
                cr = alu_ref(tx_alu_opcode, tx_alu_operand0, tx_alu_operand1, tx_alu_carryflag);
                rx_alu_ready = 1'b0;
                rx_alu_result = 8'($urandom);
                rx_alu_carryflag = 1'($urandom);
                rx_alu_zeroflag = 1'($urandom);
                rx_alu_signflag = 1'($urandom);
                repeat (alu_delay) @(negedge aclk);
                rx_alu_result = cr[7:0];
                rx_alu_carryflag = cr[8];
                rx_alu_zeroflag = (cr[7:0] == 8'd0);
                rx_alu_signflag = cr[7];
                rx_alu_ready = 1'b1;
            end
        end
    end

    task automatic check_idle(input string tag);
        check({tag, "_ctrl"}, {24'd0, tx_cmd_ready, tx_alu_enable, tx_alu_write, tx_alu_strobe,
                               tx_rsp_valid, tx_rsp_timeout, tx_alu_carryflag, tx_alu_opcode}, 32'h0000_0200);
        check({tag, "_data"}, {5'd0, tx_alu_operand0, tx_alu_operand1, tx_rsp_result, tx_rsp_flags}, 32'd0);
    endtask

    task automatic clear_carry();
        @(negedge aclk);
        rx_carry_clear = 1'b1;
        @(negedge aclk);
        rx_carry_clear = 1'b0;
        model_carry = 1'b0;
    endtask

    task automatic do_cmd(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                          input logic uc, input int dly, input int hold, input logic hang);
        logic [8:0] cr;
        logic       cin;
        logic [7:0] exp_res;
        logic [2:0] exp_flg;
        int         exp_lat;
        int         n;
        cin = uc & model_carry;
        cr = alu_ref(op, a, b, cin);
        if (hang) begin
            exp_res = 8'd0;
            exp_flg = 3'd0;
            exp_lat = LC + SC + 1 + TO;
        end else begin
            exp_res = cr[7:0];
            exp_flg = {cr[8], cr[7:0] == 8'd0, cr[7]};
            exp_lat = LC + SC + 1 + dly;
        end
        alu_delay = dly;
        alu_hang = hang;
        n = 0;
        @(negedge aclk);
        while (!tx_cmd_ready && n < 50) begin
            @(negedge aclk);
            n++;
        end
        check("cmd_ready_wait", {31'd0, tx_cmd_ready}, 32'd1);
        rx_cmd_valid = 1'b1;
        rx_cmd_opcode = op;
        rx_cmd_operand0 = a;
        rx_cmd_operand1 = b;
        rx_cmd_usecarry = uc;
        @(posedge aclk);
        #1;
        rx_cmd_valid = 1'b0;
        rx_cmd_opcode = 3'($urandom);
        rx_cmd_operand0 = 8'($urandom);
        check("accept", {tx_cmd_ready, tx_alu_enable, tx_alu_write, tx_alu_opcode, tx_alu_operand0,
                         tx_alu_operand1, tx_alu_carryflag}, {1'b0, 1'b1, 1'b1, op, a, b, cin});
        n = 0;
        while (!tx_rsp_valid && n < 200) begin
            @(posedge aclk);
            #1;
            n++;
        end
        check("latency", n, exp_lat);
        check("rsp", {tx_rsp_valid, tx_alu_enable, tx_rsp_timeout, tx_rsp_flags, tx_rsp_result},
              {1'b1, 1'b0, hang, exp_flg, exp_res});
        rx_cmd_valid = 1'b1;
        repeat (hold) begin
            @(posedge aclk);
            #1;
            check("rsp_hold", {tx_rsp_valid, tx_cmd_ready, tx_rsp_timeout, tx_rsp_flags, tx_rsp_result},
                  {1'b1, 1'b0, hang, exp_flg, exp_res});
        end
        rx_cmd_valid = 1'b0;
        rx_rsp_ready = 1'b1;
        @(posedge aclk);
        #1;
        rx_rsp_ready = 1'b0;
        check("release", {tx_rsp_valid, tx_cmd_ready, tx_alu_enable}, {1'b0, 1'b1, 1'b0});
        if (!hang) model_carry = cr[8];
    endtask

    initial begin
        #200000;
        $display("FAIL global_time_limit: got expired expected completion");
        $fatal(1, "time limit");
    end

    initial begin
        int n;
        repeat (3) @(negedge aclk);
        #1;
        check_idle("reset");
        aresetn = 1'b1;
        @(negedge aclk);
        check_idle("post_reset");

        do_cmd(3'd1, 8'h7F, 8'h01, 1'b0, 2, 0, 1'b0);
        check("carry_after_7f", {31'd0, model_carry}, 32'd0);

        do_cmd(3'd1, 8'hFF, 8'h01, 1'b0, 3, 0, 1'b0);
        do_cmd(3'd1, 8'h00, 8'h00, 1'b1, 2, 0, 1'b0);

        do_cmd(3'd1, 8'hFF, 8'h01, 1'b0, 4, 0, 1'b0);
        clear_carry();
        do_cmd(3'd1, 8'h00, 8'h00, 1'b1, 2, 0, 1'b0);

        do_cmd(3'd1, 8'hFF, 8'h01, 1'b0, 2, 0, 1'b0);
        do_cmd(3'd1, 8'h12, 8'h34, 1'b0, 2, 0, 1'b1);
        do_cmd(3'd1, 8'h00, 8'h00, 1'b1, 2, 0, 1'b0);

        do_cmd(3'd6, 8'h0F, 8'h30, 1'b0, 5, 10, 1'b0);

        // Reset while the ALU is busy
        alu_delay = 6;
        alu_hang = 1'b0;
        @(negedge aclk);
        rx_cmd_valid = 1'b1;
        rx_cmd_opcode = 3'd1;
        rx_cmd_operand0 = 8'h80;
        rx_cmd_operand1 = 8'h80;
        rx_cmd_usecarry = 1'b1;
        @(negedge aclk);
        rx_cmd_valid = 1'b0;
        n = 0;
        while (!tx_alu_strobe && n < 20) begin
            @(negedge aclk);
            n++;
        end
        check("strobe_seen", {31'd0, tx_alu_strobe}, 32'd1);
        repeat (2) @(negedge aclk);
        aresetn = 1'b0;
        #1;
        check_idle("mid_reset");
        @(negedge aclk);
        aresetn = 1'b1;
        model_carry = 1'b0;
        repeat (8) @(negedge aclk);
        check_idle("after_reset");
        do_cmd(3'd7, 8'hF0, 8'hFF, 1'b1, 2, 0, 1'b0);

        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 4) == 0) clear_carry();
            do_cmd(3'($urandom), 8'($urandom), 8'($urandom), 1'($urandom),
                   int'($urandom_range(2, 5)), int'($urandom_range(0, 3)),
                   $urandom_range(0, 9) == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
